// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator result path:
// operation codes, the default result width and the BCD converter states.
package calc_pkg;

  localparam int CALC_RES_W = 8;

  typedef enum logic [1:0] {
    FUNC_ADD = 2'b00,
    FUNC_SUB = 2'b01,
    FUNC_MUL = 2'b10,
    FUNC_DIV = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_e;

endpackage

// File: rtl/calc_dabble_step.sv
// One double-dabble iteration on the concatenated {bcd, bin} vector.
// Every BCD nibble that is 5 or more gets 3 added, then the whole vector
// shifts left by one. Purely combinational; the top reuses a single copy
// of this step on every conversion cycle.
module calc_dabble_step
  import calc_pkg::*;
#(
  parameter int RES_W  = CALC_RES_W,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS+RES_W-1:0] i_vec,
  output logic [4*DIGITS+RES_W-1:0] o_vec
);

  logic [4*DIGITS+RES_W-1:0] w_adj;

  // Add-3 correction on each BCD nibble, then shift the whole vector left.
  always_comb begin
    w_adj = i_vec;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_vec[RES_W+4*d +: 4] >= 4'd5) begin
        w_adj[RES_W+4*d +: 4] = i_vec[RES_W+4*d +: 4] + 4'd3;
      end
    end
    o_vec = w_adj << 1;
  end

endmodule

// File: rtl/calc_result_bcd.sv
// Calculator result to BCD converter.
// Captures a binary result over a valid/ready handshake, converts it to
// packed BCD one bit per cycle with a double-dabble engine, and offers the
// digits downstream over a second valid/ready handshake. A divide with a
// zero divisor skips the conversion and reports out_err instead.
// Optional build macro: SIGNED_SUB_EN -- a subtraction whose result has the
// MSB set is shown as its magnitude with out_neg raised. Without the macro
// every result is unsigned and out_neg stays low.
module calc_result_bcd
  import calc_pkg::*;
#(
  parameter int RES_W  = CALC_RES_W,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RES_W-1:0]      in_result,
  input  logic [1:0]            in_func,
  input  logic                  in_b_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_err
);

  localparam int BCD_W = 4*DIGITS;
  localparam int VEC_W = BCD_W + RES_W;
  localparam int CNT_W = $clog2(RES_W + 1);

  bcd_state_e        r_state;
  bcd_state_e        w_next_state;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  r_out_bcd;
  logic [RES_W-1:0]  r_bin;
  logic [RES_W-1:0]  w_bin_in;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_neg;
  logic              r_out_err;
  logic              r_out_neg;
  logic              w_div0;
  logic              w_neg_in;
  logic              w_accept;
  logic              w_last;
  logic [VEC_W-1:0]  w_step_out;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_div0   = (func_e'(in_func) == FUNC_DIV) && in_b_zero;
  assign w_last   = (r_cnt == CNT_W'(1));

`ifdef SIGNED_SUB_EN
  assign w_neg_in = (func_e'(in_func) == FUNC_SUB) && in_result[RES_W-1];
  assign w_bin_in = w_neg_in ? (~in_result + RES_W'(1)) : in_result;
`else
  assign w_neg_in = 1'b0;
  assign w_bin_in = in_result;
`endif

  calc_dabble_step #(
    .RES_W  (RES_W),
    .DIGITS (DIGITS)
  ) u_step (
    .i_vec ({r_bcd, r_bin}),
    .o_vec (w_step_out)
  );

  assign out_bcd = r_out_bcd;
  assign out_neg = r_out_neg;
  assign out_err = r_out_err;

  // Next-state selection and handshake outputs decoded from the state.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = CONV;
      end
      CONV: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Capture, iterate and publish. The divide-by-zero case still passes
  // through one CONV cycle (counter loaded with 1) so its result appears
  // exactly one cycle after acceptance, with the digits forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_neg     <= 1'b0;
      r_out_bcd <= '0;
      r_out_neg <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bcd <= '0;
            r_neg <= w_neg_in;
            if (w_div0) begin
              r_bin <= '0;
              r_err <= 1'b1;
              r_cnt <= CNT_W'(1);
            end else begin
              r_bin <= w_bin_in;
              r_err <= 1'b0;
              r_cnt <= CNT_W'(RES_W);
            end
          end
        end
        CONV: begin
          r_bcd <= w_step_out[VEC_W-1 -: BCD_W];
          r_bin <= w_step_out[RES_W-1:0];
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out_bcd <= r_err ? '0 : w_step_out[VEC_W-1 -: BCD_W];
            r_out_err <= r_err;
            r_out_neg <= r_neg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Testbench for calc_result_bcd: reset state, a table of directed vectors,
// backpressure and mid-conversion reset sequences, then random results
// compared against a decimal-arithmetic reference model.
module tb_calc_result_bcd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_result;
  logic [1:0]  in_func;
  logic        in_b_zero;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        out_neg;
  logic        out_err;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [7:0]  res;
    logic [1:0]  func;
    logic        bz;
    logic [11:0] expBcd;
    logic        expNeg;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  calc_result_bcd #(.RES_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_func   (in_func),
    .in_b_zero (in_b_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits come from division by powers of ten.
  function automatic void refModel(input logic [7:0] res, input logic [1:0] f, input logic bz,
                                   output logic [11:0] bcd, output logic neg,
                                   output logic err, output int lat);
    int v;
    v   = int'(res);
    neg = 1'b0;
    err = (f == 2'b11) && bz;
`ifdef SIGNED_SUB_EN
    if (f == 2'b01 && v >= 128) begin
      v   = 256 - v;
      neg = 1'b1;
    end
`endif
    if (err) begin
      bcd = 12'h000;
      neg = 1'b0;
      lat = 1;
    end else begin
      bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      lat = 8;
    end
  endfunction

  // Present one result and let it be accepted; returns at acceptance edge +1.
  task automatic applyStimulus(input logic [7:0] res, input logic [1:0] f, input logic bz);
    checkVal("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_result = res;
    in_func   = f;
    in_b_zero = bz;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Count cycles to out_valid (bounded) and compare the presented result.
  task automatic checkOutput(input string name, input logic [11:0] expBcd, input logic expNeg,
                             input logic expErr, input int expLat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkVal({name, " latency"}, 32'(lat), 32'(expLat));
    checkVal({name, " bcd"}, 32'(out_bcd), 32'(expBcd));
    checkVal({name, " neg"}, 32'(out_neg), 32'(expNeg));
    checkVal({name, " err"}, 32'(out_err), 32'(expErr));
  endtask

  // Complete the output handshake after an optional stall.
  task automatic releaseOutput(input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("out_valid after handshake", 32'(out_valid), 32'd0);
    checkVal("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [11:0] eBcd;
    logic        eNeg;
    logic        eErr;
    int          eLat;
    logic [7:0]  rRes;
    logic [1:0]  rFunc;
    logic        rBz;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_func   = '0;
    in_b_zero = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'hE1, 2'b10, 1'b0, 12'h225, 1'b0, 1'b0, 8};
    vecs[1] = '{8'h09, 2'b00, 1'b0, 12'h009, 1'b0, 1'b0, 8};
    vecs[2] = '{8'h0A, 2'b00, 1'b0, 12'h010, 1'b0, 1'b0, 8};
    vecs[3] = '{8'hFF, 2'b10, 1'b0, 12'h255, 1'b0, 1'b0, 8};
    vecs[4] = '{8'h00, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0, 8};
    vecs[5] = '{8'h00, 2'b11, 1'b1, 12'h000, 1'b0, 1'b1, 1};
    vecs[6] = '{8'h07, 2'b11, 1'b0, 12'h007, 1'b0, 1'b0, 8};
`ifdef SIGNED_SUB_EN
    vecs[7] = '{8'hFE, 2'b01, 1'b0, 12'h002, 1'b1, 1'b0, 8};
`else
    vecs[7] = '{8'hFE, 2'b01, 1'b0, 12'h254, 1'b0, 1'b0, 8};
`endif
    vecs[8] = '{8'h80, 2'b00, 1'b1, 12'h128, 1'b0, 1'b0, 8};
    vecs[9] = '{8'h63, 2'b10, 1'b1, 12'h099, 1'b0, 1'b0, 8};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("reset in_ready", 32'(in_ready), 32'd1);
    checkVal("reset out_valid", 32'(out_valid), 32'd0);
    checkVal("reset out_bcd", 32'(out_bcd), 32'h000);
    checkVal("reset out_neg", 32'(out_neg), 32'd0);
    checkVal("reset out_err", 32'(out_err), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].res, vecs[i].func, vecs[i].bz);
      checkOutput($sformatf("vec%0d", i), vecs[i].expBcd, vecs[i].expNeg,
                  vecs[i].expErr, vecs[i].expLat);
      releaseOutput(0);
    end

    // Backpressure: output held for 5 cycles, extra input ignored meanwhile.
    applyStimulus(8'd99, 2'b00, 1'b0);
    checkOutput("bp", 12'h099, 1'b0, 1'b0, 8);
    in_valid  = 1'b1;
    in_result = 8'h11;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkVal("bp out_valid held", 32'(out_valid), 32'd1);
      checkVal("bp in_ready low", 32'(in_ready), 32'd0);
      checkVal("bp out_bcd held", 32'(out_bcd), 32'h099);
      checkVal("bp out_err held", 32'(out_err), 32'd0);
    end
    in_valid = 1'b0;
    releaseOutput(0);

    // Reset on the 4th conversion cycle aborts and clears the outputs.
    applyStimulus(8'hC8, 2'b00, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkVal("midrst in_ready", 32'(in_ready), 32'd1);
    checkVal("midrst out_valid", 32'(out_valid), 32'd0);
    checkVal("midrst out_bcd", 32'(out_bcd), 32'h000);
    checkVal("midrst out_err", 32'(out_err), 32'd0);
    applyStimulus(8'h37, 2'b00, 1'b0);
    checkOutput("after midrst", 12'h055, 1'b0, 1'b0, 8);
    releaseOutput(0);

    // Random results against the reference model with random stalls.
    for (int n = 0; n < 40; n++) begin
      rRes  = 8'($urandom);
      rFunc = 2'($urandom);
      rBz   = 1'($urandom);
      refModel(rRes, rFunc, rBz, eBcd, eNeg, eErr, eLat);
      applyStimulus(rRes, rFunc, rBz);
      checkOutput($sformatf("rand%0d r=%0h f=%0d bz=%0d", n, rRes, rFunc, rBz),
                  eBcd, eNeg, eErr, eLat);
      releaseOutput(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
